aes_col_unit: RTL and testbench
===============================

# aes_col_unit

Iterative execution unit for the custom-0 AES instruction (`funct3 = 000`), which the decoder recognises but does not execute. The CPU FSM asserts `start` with operands and the direction bit (`instr[25]`). The unit pushes the four bytes of `rs2` through one shared S-box, one byte per cycle. It accumulates a MixColumns (or InvMixColumns) column, XORs the column with `rs1`, and returns a 32-bit result to the CPU FSM with a one-cycle `done` pulse.

## Interface
- No parameters; the design is fixed at 32-bit operands and AES GF(2^8) with polynomial 0x11B.
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request from the CPU FSM; sampled only in IDLE.
- `aes_dec`  in  1  0 = encrypt direction, 1 = decrypt direction (`instr[25]`).
- `rs1`  in  32  value XORed onto the column (round-key word).
- `rs2`  in  32  input column; byte i = `rs2[8i+7:8i]` is row i.
- `ready`  out  1  1 while in IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  32  output column; row r = `result[8r+7:8r]`.

## Operation
- States:
  - IDLE: `ready = 1`.
  - SUB: byte index `idx` counts 0..3.
  - DONE.
- IDLE → SUB when `start = 1`. In that cycle the unit latches `rs1`, `rs2` and `aes_dec`, clears `acc` (32 bits) and sets `idx = 0`.
- SUB, each cycle:
  - s = S(byte idx), or S⁻¹ when `dec` is set.
  - For each row r: `acc[r] ^= gmul(s, coef[(idx − r) mod 4])`.
  - Coefficients: encrypt {2,3,1,1}, decrypt {0E,0B,0D,09}.
- SUB with `idx = 3` → DONE. In that cycle the unit registers `result = rs1_q ^ acc_next`.
- DONE: `done = 1` for exactly one cycle, then → IDLE.
- `result` holds its value until the next DONE. It is not cleared on leaving DONE.
- `start` outside IDLE is ignored: no queueing and no error.
- `start` in the DONE cycle is ignored. A new request is accepted no earlier than the following (IDLE) cycle.
- Operands are latched at accept, so changes on `rs1`, `rs2` or `aes_dec` while busy have no effect.
- Encrypt gives SubBytes then MixColumns. Decrypt gives InvSubBytes then InvMixColumns. Decrypt is the equivalent-inverse-cipher ordering, not the exact inverse of encrypt.
- GF arithmetic: `gmul` uses only xtime chains (xtime = shift left, XOR 0x1B on carry). No multipliers are inferred.

## Timing
- Reset: state = IDLE, `ready = 1`, `done = 0`, `result = 0`, `acc = 0`, `idx = 0`.
- Reset mid-operation aborts immediately. There is no `done` pulse, and the next cycle is IDLE.
- Latency: `start` sampled at edge k → SUB during cycles k+1..k+4 → `done` high during cycle k+5.
- Throughput: one operation per 6 cycles at most. `ready` drops in the cycle after accept.
- `done` and `result` are registered outputs with no combinational path from any input. `ready` is decoded from the state register only.
- `start` held high continuously: operations are accepted back-to-back, each 6 cycles apart.
- The register-file write of `result` is the CPU FSM's responsibility on `done`.

## Structure
- Shared package `aes_pkg`:
  - state encoding localparams (IDLE, SUB, DONE);
  - the encrypt and decrypt coefficient arrays;
  - the `xtime`/`gmul` functions;
  - the custom-0 opcode constant `7'b0001011` and `AES_FUNCT3 = 3'b000`.
- One sub-module, `aes_sbox`: combinational forward/inverse S-box with 8-bit input, `inv` select and 8-bit output. It is instantiated once and shared across the four byte cycles.

## Test plan
- Reset, then encrypt with `rs1 = 0`, `rs2 = 0` → `done` at k+5, `result = 0x63636363`. `ready` is 0 for cycles k+1..k+5.
- Encrypt with `rs2 = 0x6850829F`:
  - `rs1 = 0` → `result = 0xBCA14D8E` (S-box gives DB 13 53 45; MixColumns gives 8E 4D A1 BC).
  - `rs1 = 0xFFFFFFFF` → `result = 0x435EB271`.
- Decrypt with `rs1 = 0`:
  - `rs2 = 0` → `0x52525252`.
  - `rs2 = 0x63636363` → `0x00000000`.
- Pulse `start` in cycles k+2 and k+5 while busy, and change `rs2` mid-operation → exactly one `done`, with the result of the originally latched operands. A `start` at k+6 is accepted.
- Assert `rst` at cycle k+3 of an operation → no `done`. Next cycle: `ready = 1`, `result = 0`. A fresh operation then completes normally.
- Hold `start` high for 3 operations with alternating `aes_dec` → `done` at k+5, k+11, k+17, each with the correct direction's result.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, coefficients and GF(2^8) helpers for the AES column unit
package aes_pkg;
  localparam logic [6:0] AES_OPCODE = 7'b0001011;
  localparam logic [2:0] AES_FUNCT3 = 3'b000;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] ENC_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] DEC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = xtime(t);
    end
    return p;
  endfunction
  function automatic logic [7:0] coef(input logic dec, input logic [1:0] i);
    return dec ? DEC_COEF[i] : ENC_COEF[i];
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward/inverse S-box built from GF inversion plus affine map
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  logic [7:0] pre;
  logic [7:0] y;
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  // x^254 by square-and-multiply; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  always_comb begin
    pre = inv ? (rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05) : din;
    y = ginv(pre);
    dout = inv ? y : (y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63);
  end
endmodule

// File: rtl/aes_col_unit.sv
// aes_col_unit: iterative SubBytes+MixColumns (or inverse) column unit with round-key XOR
module aes_col_unit
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        aes_dec,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic        done,
  output logic [31:0] result
);
  logic [1:0]  state;
  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        dec_q;
  logic [7:0]  s;
  aes_sbox u_sbox (.din(rs2_q[{idx, 3'b000} +: 8]), .inv(dec_q), .dout(s));
  assign ready = state == ST_IDLE;
  // byte idx contributes to row r with the circulant coefficient at (idx - r) mod 4
  always_comb begin
    for (int r = 0; r < 4; r++)
      acc_next[8*r +: 8] = acc[8*r +: 8] ^ gmul(s, coef(dec_q, idx - 2'(r)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= 2'd0;
      acc    <= 32'h0;
      rs1_q  <= 32'h0;
      rs2_q  <= 32'h0;
      dec_q  <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          rs1_q <= rs1;
          rs2_q <= rs2;
          dec_q <= aes_dec;
          acc   <= 32'h0;
          idx   <= 2'd0;
          state <= ST_SUB;
        end
        ST_SUB: begin
          acc <= acc_next;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            result <= rs1_q ^ acc_next;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_col_unit.sv
// tb_aes_col_unit: scoreboard bench with an independent AES column reference model
module tb_aes_col_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        aes_dec = 1'b0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        ready;
  logic        done;
  logic [31:0] result;

  aes_col_unit dut (.clk(clk), .rst(rst), .start(start), .aes_dec(aes_dec), .rs1(rs1),
                    .rs2(rs2), .ready(ready), .done(done), .result(result));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] res; int cyc;} exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          idle_from = 0;
  int          nacc = 0;
  int          total = 0;
  int          passed = 0;
  bit          armed = 0;
  bit          exp_done;
  logic [31:0] model_res = 32'h0;
  logic [7:0]  sb [256];
  logic [7:0]  isb [256];
  logic [7:0]  ec [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  logic [7:0]  dc [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  always @(posedge clk) cyc <= cyc + 1;

  // polynomial product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] pm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_fn(input logic d, input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  sv [4];
    logic [7:0]  m;
    logic [31:0] o;
    for (int c = 0; c < 4; c++) sv[c] = d ? isb[b[8*c +: 8]] : sb[b[8*c +: 8]];
    for (int r = 0; r < 4; r++) begin
      m = 8'h00;
      for (int c = 0; c < 4; c++) m = m ^ pm(d ? dc[(c - r + 4) % 4] : ec[(c - r + 4) % 4], sv[c]);
      o[8*r +: 8] = m;
    end
    return o ^ a;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, expv);
  endtask

  // one call per clock cycle; the bench's own view of busy/idle decides acceptance
  task automatic drv(input logic r, input logic st, input logic d, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] expv, input bit use_exp);
    @(negedge clk);
    rst = r; start = st; aes_dec = d; rs1 = a; rs2 = b;
    if (r) begin
      q.delete();
      idle_from = cyc + 1;
      model_res = 32'h0;
    end else if (st && cyc >= idle_from) begin
      q.push_back('{use_exp ? expv : ref_fn(d, a, b), cyc + 5});
      idle_from = cyc + 6;
      nacc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic op_exp(input logic d, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    drv(0, 1, d, a, b, e, 1);
    idle(6);
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      exp_done = q.size() > 0 && q[0].cyc == cyc;
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        model_res = q[0].res;
        void'(q.pop_front());
      end
      chk("result", result, model_res);
      chk("ready", 32'(ready), 32'(cyc >= idle_from));
    end
  end

  initial begin
    logic [7:0] iv;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (pm(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        t[i] = iv[i] ^ iv[(i + 4) % 8] ^ iv[(i + 5) % 8] ^ iv[(i + 6) % 8] ^ iv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sb[x] = t;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    armed = 1;
    drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    idle(2);
    op_exp(0, 32'h0, 32'h0, 32'h63636363);
    op_exp(0, 32'h0, 32'h6850829f, 32'hbca14d8e);
    op_exp(0, 32'hffffffff, 32'h6850829f, 32'h435eb271);
    op_exp(1, 32'h0, 32'h0, 32'h52525252);
    op_exp(1, 32'h0, 32'h63636363, 32'h00000000);
    drv(0, 1, 0, 32'h01020304, 32'hdeadbeef, 32'h0, 0);
    drv(0, 0, 1, 32'h0, 32'h12345678, 32'h0, 0);
    drv(0, 1, 1, 32'h0, 32'h9abcdef0, 32'h0, 0);
    idle(2);
    drv(0, 1, 1, 32'h5a5a5a5a, 32'h11111111, 32'h0, 0);
    drv(0, 1, 0, 32'hcafef00d, 32'h0badf00d, 32'h0, 0);
    idle(7);
    drv(0, 1, 0, $urandom, $urandom, 32'h0, 0);
    idle(2);
    drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    drv(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    op_exp(0, 32'h0, 32'h6850829f, 32'hbca14d8e);
    for (int i = 0; i < 18; i++) drv(0, 1, nacc[0], $urandom, $urandom, 32'h0, 0);
    idle(6);
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 1'($urandom), $urandom, $urandom, 32'h0, 0);
    idle(8);
    chk("drain", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
